// File: rtl/atomic_pkg.sv
// -----------------------------------------------------------------------------
// atomic_pkg
// Shared types for the atomic ALU command sequencer:
//   opcode_e  - named opcodes the controller interprets (others pass through raw)
//   state_e   - controller FSM encoding
//   flags_t   - ALU flag bundle {o, c, z, n}
//   cmd_width - packed command width for a given register address width
// -----------------------------------------------------------------------------
package atomic_pkg;

  localparam int OPCODE_W = 3;

  // Only the codes the controller itself treats specially are named; codes
  // 3'b010..3'b110 travel to the ALU unchanged.
  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_CAS = 3'b111
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_e;

  typedef struct packed {
    logic o;
    logic c;
    logic z;
    logic n;
  } flags_t;

  // Command layout is {opcode, addr1, addr2, addr3}, MSB first.
  function automatic int cmd_width(input int addr_w);
    return OPCODE_W + 3 * addr_w;
  endfunction

endpackage

// File: rtl/atomic_op_controller_if.sv
// -----------------------------------------------------------------------------
// atomic_op_controller_if
// Bundles the command handshake, the ALU operand/result path and the debug
// read port of atomic_op_controller.
//   master : command source + external ALU + debug reader (the environment)
//   slave  : the controller
// Signals:
//   cmd_valid/cmd_ready/command      command handshake
//   alu_op_code/data_a/data_b        operands driven to the ALU
//   alu_result, O, C, Z, N           combinational ALU response
//   flags_q                          {O,C,Z,N} latched from last non-CAS op
//   done, cas_ok                     completion pulse and CAS outcome
//   dbg_addr/dbg_data                combinational register file peek
// -----------------------------------------------------------------------------
interface atomic_op_controller_if
  import atomic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
);

  localparam int ADDR_W = $clog2(NREGS);
  localparam int CMD_W  = cmd_width(ADDR_W);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [CMD_W-1:0]    command;

  logic [OPCODE_W-1:0] alu_op_code;
  logic [DATA_W-1:0]   data_a;
  logic [DATA_W-1:0]   data_b;
  logic [DATA_W-1:0]   alu_result;
  logic                O;
  logic                C;
  logic                Z;
  logic                N;

  logic [3:0]          flags_q;
  logic                done;
  logic                cas_ok;

  logic [ADDR_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output cmd_valid, command, alu_result, O, C, Z, N, dbg_addr,
    input  cmd_ready, alu_op_code, data_a, data_b, flags_q, done, cas_ok,
           dbg_data
  );

  modport slave (
    input  cmd_valid, command, alu_result, O, C, Z, N, dbg_addr,
    output cmd_ready, alu_op_code, data_a, data_b, flags_q, done, cas_ok,
           dbg_data
  );

endinterface

// File: rtl/atomic_regfile.sv
// -----------------------------------------------------------------------------
// atomic_regfile
// NREGS x DATA_W register file for the atomic sequencer.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset (all regs 0)
//   rd_addr_a/b/c, rd_data_* three combinational read ports
//   dbg_addr, dbg_data       combinational debug read port
//   wr_en, wr_addr, wr_data  general write port
//   status_we, status_data   dedicated write to the last register (STATUS_IDX);
//                            wins over the general port on an address clash
// -----------------------------------------------------------------------------
module atomic_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  input  logic [$clog2(NREGS)-1:0] rd_addr_c,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic [DATA_W-1:0]        rd_data_c,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     status_we,
  input  logic [DATA_W-1:0]        status_data
);

  localparam int                ADDR_W     = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] STATUS_IDX = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] mem [NREGS];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
  assign rd_data_c = mem[rd_addr_c];
  assign dbg_data  = mem[dbg_addr];

  // NOTE: the array is reset, so it maps onto flops rather than a RAM macro;
  // that is intended here - the file is tiny and must read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      // Issued after the general write so it takes priority when both target
      // STATUS_IDX in the same cycle.
      if (status_we) begin
        mem[STATUS_IDX] <= status_data;
      end
    end
  end

endmodule

// File: rtl/atomic_op_controller.sv
// -----------------------------------------------------------------------------
// atomic_op_controller
// Two-state command sequencer in front of an external combinational ALU.
// IDLE accepts a command and registers the ALU operands; EVAL writes the ALU
// result (or the CAS outcome) back, pulses done and returns to IDLE.
// CAS {loc, new, expected}: the ALU subtracts expected from rf[loc]; Z=1 swaps
// rf[new] into loc, Z=0 returns the observed value into the expected register.
// The status register (last entry) records the CAS outcome.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  atomic_op_controller_if.slave (handshake, ALU path, flags, debug read)
// -----------------------------------------------------------------------------
module atomic_op_controller
  import atomic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  atomic_op_controller_if.slave  bus
);

  localparam int ADDR_W = $clog2(NREGS);
  localparam int CMD_W  = cmd_width(ADDR_W);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_EVAL = EVAL;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [OPCODE_W-1:0] cmd_op;
  logic [ADDR_W-1:0]   cmd_a1;
  logic [ADDR_W-1:0]   cmd_a2;
  logic [ADDR_W-1:0]   cmd_a3;
  logic                cmd_is_cas;

  assign cmd_op     = bus.command[CMD_W-1 -: OPCODE_W];
  assign cmd_a1     = bus.command[3*ADDR_W-1 -: ADDR_W];
  assign cmd_a2     = bus.command[2*ADDR_W-1 -: ADDR_W];
  assign cmd_a3     = bus.command[ADDR_W-1:0];
  assign cmd_is_cas = (cmd_op == OP_CAS);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  logic [0:0]          state;
  logic                cas_q;
  logic [ADDR_W-1:0]   a1_q;
  logic [ADDR_W-1:0]   a2_q;
  logic [ADDR_W-1:0]   a3_q;
  logic [OPCODE_W-1:0] op_code_q;
  logic [DATA_W-1:0]   data_a_q;
  logic [DATA_W-1:0]   data_b_q;
  flags_t              flags_r;
  logic                done_q;
  logic                cas_ok_q;

  logic                accept;
  logic                in_eval;

  assign accept  = bus.cmd_valid && (state == S_IDLE);
  assign in_eval = (state == S_EVAL);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_b_addr;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] swap_val;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              status_we;
  logic [DATA_W-1:0] status_data;

  // A CAS compares rf[loc] against rf[expected], so port B follows addr3.
  assign rd_b_addr = cmd_is_cas ? cmd_a3 : cmd_a2;

  atomic_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_a   (cmd_a1),
    .rd_addr_b   (rd_b_addr),
    .rd_addr_c   (a2_q),
    .rd_data_a   (rf_a),
    .rd_data_b   (rf_b),
    .rd_data_c   (swap_val),
    .dbg_addr    (bus.dbg_addr),
    .dbg_data    (bus.dbg_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .status_we   (status_we),
    .status_data (status_data)
  );

  // ---------------------------------------------------------------------------
  // Writeback selection (EVAL only)
  // The swap value is read during EVAL through port C: nothing is written
  // between accept and EVAL, so this still sees the pre-command contents.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block so no path can
  // leave it unassigned - that is what keeps always_comb from inferring latches.
  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = a3_q;
    wr_data     = bus.alu_result;
    status_we   = 1'b0;
    status_data = '0;
    if (in_eval) begin
      wr_en = 1'b1;
      if (cas_q) begin
        status_we   = 1'b1;
        status_data = DATA_W'(bus.Z);
        if (bus.Z) begin
          wr_addr = a1_q;
          wr_data = swap_val;
        end else begin
          wr_addr = a3_q;
          wr_data = data_a_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and operand/flag registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout, so every register samples the
  // values present before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cas_q     <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      a3_q      <= '0;
      op_code_q <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      flags_r   <= '0;
      done_q    <= 1'b0;
      cas_ok_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      cas_ok_q <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          cas_q     <= cmd_is_cas;
          a1_q      <= cmd_a1;
          a2_q      <= cmd_a2;
          a3_q      <= cmd_a3;
          data_a_q  <= rf_a;
          data_b_q  <= rf_b;
          op_code_q <= cmd_is_cas ? OP_SUB : cmd_op;
          state     <= S_EVAL;
        end
      end else begin
        done_q   <= 1'b1;
        cas_ok_q <= cas_q && bus.Z;
        if (!cas_q) begin
          flags_r <= '{o: bus.O, c: bus.C, z: bus.Z, n: bus.N};
        end
        state <= S_IDLE;
      end
    end
  end

  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.alu_op_code = op_code_q;
  assign bus.data_a      = data_a_q;
  assign bus.data_b      = data_b_q;
  assign bus.flags_q     = flags_r;
  assign bus.done        = done_q;
  assign bus.cas_ok      = cas_ok_q;

endmodule

// File: tb/tb_atomic_op_controller.sv
// -----------------------------------------------------------------------------
// tb_atomic_op_controller
// Drives two controller instances (8x32 default and 16x16) with a behavioural
// ALU. Each 8x32 command updates a reference register file and pushes the
// expected completion onto a queue; every done pulse pops and compares it.
// -----------------------------------------------------------------------------
module tb_atomic_op_controller;

  localparam logic [2:0] T_ADD = 3'b000;
  localparam logic [2:0] T_SUB = 3'b001;
  localparam logic [2:0] T_XOR = 3'b100;
  localparam logic [2:0] T_SHL = 3'b101;
  localparam logic [2:0] T_INC = 3'b110;
  localparam logic [2:0] T_CAS = 3'b111;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  atomic_op_controller_if #(.DATA_W(32), .NREGS(8))  u_if ();
  atomic_op_controller_if #(.DATA_W(16), .NREGS(16)) u_if16 ();

  atomic_op_controller #(.DATA_W(32), .NREGS(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  atomic_op_controller #(.DATA_W(16), .NREGS(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (u_if16.slave)
  );

  // ---------------------------------------------------------------------------
  // Behavioural ALUs. Returned word is {O, C, Z, N, result}.
  // 010 AND, 011 OR, 100 XOR, 101 shift-left-1 of a, 110 a+1.
  // ---------------------------------------------------------------------------
  function automatic logic [35:0] alu32(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        o;
    logic        c;
    o = 1'b0;
    c = 1'b0;
    case (op)
      3'b000: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << 1;
      3'b110:  r = a + 32'd1;
      default: begin
        r = a - b;
        c = (a < b);
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
    endcase
    return {o, c, (r == 32'd0), r[31], r};
  endfunction

  function automatic logic [19:0] alu16(input logic [2:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b110:  r = a + 16'd1;
      default: r = a;
    endcase
    return {1'b0, 1'b0, (r == 16'd0), r[15], r};
  endfunction

  logic [35:0] alu_out;
  logic [19:0] alu16_out;

  assign alu_out         = alu32(u_if.alu_op_code, u_if.data_a, u_if.data_b);
  assign u_if.alu_result = alu_out[31:0];
  assign u_if.N          = alu_out[32];
  assign u_if.Z          = alu_out[33];
  assign u_if.C          = alu_out[34];
  assign u_if.O          = alu_out[35];

  assign alu16_out         = alu16(u_if16.alu_op_code, u_if16.data_a, u_if16.data_b);
  assign u_if16.alu_result = alu16_out[15:0];
  assign u_if16.N          = alu16_out[16];
  assign u_if16.Z          = alu16_out[17];
  assign u_if16.C          = alu16_out[18];
  assign u_if16.O          = alu16_out[19];

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        ok;
    logic [3:0]  flags;
    logic [2:0]  addr;
    logic [31:0] val;
    logic [31:0] status;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mrf [8];
  logic [3:0]  mflags;

  int   n_checks;
  int   n_fail;
  int   done_cnt;
  logic accepted;
  logic last_cas_ok;
  logic cas16;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mrf[i] = 32'd0;
    mflags = 4'd0;
    q.delete();
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [2:0] a1,
                          input logic [2:0] a2, input logic [2:0] a3);
    exp_t        e;
    logic [35:0] r;
    if (op == T_CAS) begin
      r    = alu32(T_SUB, mrf[a1], mrf[a3]);
      e.ok = r[33];
      if (e.ok) begin
        mrf[a1] = mrf[a2];
        e.addr  = a1;
      end else begin
        mrf[a3] = mrf[a1];
        e.addr  = a3;
      end
      mrf[7] = {31'd0, e.ok};
    end else begin
      r       = alu32(op, mrf[a1], mrf[a2]);
      mrf[a3] = r[31:0];
      mflags  = r[35:32];
      e.ok    = 1'b0;
      e.addr  = a3;
    end
    e.flags  = mflags;
    e.val    = mrf[e.addr];
    e.status = mrf[7];
    q.push_back(e);
  endtask

  // One clock: sample acceptance before the edge, look at outputs #1 after it.
  task automatic cycle();
    logic acc;
    exp_t e;
    acc = u_if.cmd_valid && u_if.cmd_ready;
    @(posedge clk);
    #1;
    accepted = acc;
    if (u_if.done) begin
      done_cnt++;
      last_cas_ok = u_if.cas_ok;
      if (q.size() == 0) begin
        check("unexpected_done", 64'(u_if.done), 64'(0));
      end else begin
        e = q.pop_front();
        check("cas_ok", 64'(u_if.cas_ok), 64'(e.ok));
        check("flags_q", 64'(u_if.flags_q), 64'(e.flags));
        u_if.dbg_addr = e.addr;
        #1;
        check("writeback", 64'(u_if.dbg_data), 64'(e.val));
        u_if.dbg_addr = 3'd7;
        #1;
        check("status_reg", 64'(u_if.dbg_data), 64'(e.status));
      end
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] a1,
                       input logic [2:0] a2, input logic [2:0] a3);
    int n;
    u_if.command   = {op, a1, a2, a3};
    u_if.cmd_valid = 1'b1;
    push_cmd(op, a1, a2, a3);
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 20) begin
      cycle();
      n++;
    end
    u_if.cmd_valid = 1'b0;
    if (!accepted) check("accept_timeout", 64'(accepted), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      cycle();
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  task automatic run(input logic [2:0] op, input logic [2:0] a1,
                     input logic [2:0] a2, input logic [2:0] a3);
    issue(op, a1, a2, a3);
    drain();
  endtask

  // Builds a constant in dst from r0 (=0) using ADD, shift and increment.
  task automatic load_const(input logic [2:0] dst, input logic [7:0] val);
    logic started;
    started = 1'b0;
    run(T_ADD, 3'd0, 3'd0, dst);
    for (int b = 7; b >= 0; b--) begin
      if (started) run(T_SHL, dst, 3'd0, dst);
      if (val[b]) begin
        run(T_INC, dst, 3'd0, dst);
        started = 1'b1;
      end
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    u_if.dbg_addr = a;
    #1;
    d = u_if.dbg_data;
  endtask

  task automatic rd16(input logic [3:0] a, output logic [15:0] d);
    u_if16.dbg_addr = a;
    #1;
    d = u_if16.dbg_data;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] a3);
    logic acc;
    int   n;
    u_if16.command   = {op, a1, a2, a3};
    u_if16.cmd_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 10) begin
      acc = u_if16.cmd_valid && u_if16.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    u_if16.cmd_valid = 1'b0;
    n = 0;
    while (!u_if16.done && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("dut16_done", 64'(u_if16.done), 64'(1));
    cas16 = u_if16.cas_ok;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [31:0] d;
  logic [15:0] d16;
  logic [3:0]  fsave;
  logic [2:0]  s_op [4];
  logic [2:0]  s_a1 [4];
  logic [2:0]  s_a2 [4];
  logic [2:0]  s_a3 [4];
  int          k;
  int          n;
  int          last_n;
  int          done_base;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    accepted = 1'b0;
    last_cas_ok = 1'b0;
    cas16    = 1'b0;
    u_if.cmd_valid   = 1'b0;
    u_if.command     = '0;
    u_if.dbg_addr    = '0;
    u_if16.cmd_valid = 1'b0;
    u_if16.command   = '0;
    u_if16.dbg_addr  = '0;
    model_reset();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_cmd_ready", 64'(u_if.cmd_ready), 64'(1));
    check("rst_done", 64'(u_if.done), 64'(0));
    check("rst_cas_ok", 64'(u_if.cas_ok), 64'(0));
    check("rst_data_a", 64'(u_if.data_a), 64'(0));
    check("rst_data_b", 64'(u_if.data_b), 64'(0));
    check("rst_op_code", 64'(u_if.alu_op_code), 64'(0));
    check("rst_flags", 64'(u_if.flags_q), 64'(0));
    rd(3'd7, d);
    check("rst_r7", 64'(d), 64'(0));

    // ADD r1(5) + r2(7) -> r3 with cycle-exact handshake timing
    load_const(3'd1, 8'd5);
    load_const(3'd2, 8'd7);
    issue(T_ADD, 3'd1, 3'd2, 3'd3);
    check("add_ready_low", 64'(u_if.cmd_ready), 64'(0));
    check("add_done_early", 64'(u_if.done), 64'(0));
    check("add_data_a", 64'(u_if.data_a), 64'(5));
    check("add_data_b", 64'(u_if.data_b), 64'(7));
    cycle();
    check("add_done", 64'(u_if.done), 64'(1));
    check("add_ready_back", 64'(u_if.cmd_ready), 64'(1));
    rd(3'd3, d);
    check("add_r3", 64'(d), 64'(12));
    check("add_flags", 64'(u_if.flags_q), 64'(4'b0000));
    cycle();
    check("add_done_one_cycle", 64'(u_if.done), 64'(0));

    // SUB r1,r1 -> r4 with r1 = 9
    load_const(3'd1, 8'd9);
    run(T_SUB, 3'd1, 3'd1, 3'd4);
    rd(3'd4, d);
    check("sub_r4", 64'(d), 64'(0));
    check("sub_flags", 64'(u_if.flags_q), 64'(4'b0010));

    // CAS success: r1 == r3 == 10, new value r2 = 99
    load_const(3'd1, 8'd10);
    load_const(3'd2, 8'd99);
    load_const(3'd3, 8'd10);
    fsave = mflags;
    issue(T_CAS, 3'd1, 3'd2, 3'd3);
    check("cas_op_code", 64'(u_if.alu_op_code), 64'(T_SUB));
    check("cas_data_b", 64'(u_if.data_b), 64'(10));
    drain();
    check("cas1_ok", 64'(last_cas_ok), 64'(1));
    check("cas1_flags_kept", 64'(u_if.flags_q), 64'(fsave));
    rd(3'd1, d);
    check("cas1_r1", 64'(d), 64'(99));
    rd(3'd7, d);
    check("cas1_r7", 64'(d), 64'(1));

    // CAS failure: r1 = 10, expected r3 = 4 -> r3 receives observed 10
    load_const(3'd1, 8'd10);
    load_const(3'd3, 8'd4);
    run(T_CAS, 3'd1, 3'd2, 3'd3);
    check("cas2_ok", 64'(last_cas_ok), 64'(0));
    rd(3'd1, d);
    check("cas2_r1", 64'(d), 64'(10));
    rd(3'd3, d);
    check("cas2_r3", 64'(d), 64'(10));
    rd(3'd7, d);
    check("cas2_r7", 64'(d), 64'(0));

    // cmd_valid held high across four back-to-back commands
    s_op[0] = T_ADD; s_a1[0] = 3'd1; s_a2[0] = 3'd2; s_a3[0] = 3'd4;
    s_op[1] = T_SUB; s_a1[1] = 3'd2; s_a2[1] = 3'd1; s_a3[1] = 3'd5;
    s_op[2] = T_XOR; s_a1[2] = 3'd4; s_a2[2] = 3'd5; s_a3[2] = 3'd6;
    s_op[3] = T_CAS; s_a1[3] = 3'd6; s_a2[3] = 3'd1; s_a3[3] = 3'd6;
    done_base = done_cnt;
    k = 0;
    n = 0;
    last_n = 0;
    u_if.command   = {s_op[0], s_a1[0], s_a2[0], s_a3[0]};
    u_if.cmd_valid = 1'b1;
    push_cmd(s_op[0], s_a1[0], s_a2[0], s_a3[0]);
    while (k < 4 && n < 40) begin
      cycle();
      n++;
      if (accepted) begin
        if (k > 0) check("stream_spacing", 64'(n - last_n), 64'(2));
        last_n = n;
        k++;
        if (k < 4) begin
          u_if.command = {s_op[k], s_a1[k], s_a2[k], s_a3[k]};
          push_cmd(s_op[k], s_a1[k], s_a2[k], s_a3[k]);
        end else begin
          u_if.cmd_valid = 1'b0;
        end
      end
    end
    u_if.cmd_valid = 1'b0;
    check("stream_accepts", 64'(k), 64'(4));
    drain();
    check("stream_done_pulses", 64'(done_cnt - done_base), 64'(4));
    rd(3'd6, d);
    check("stream_r6", 64'(d), 64'(10));

    // Whole register file against the reference model
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      check("rf_final", 64'(d), 64'(mrf[i]));
    end

    // Reset during EVAL of ADD -> r5
    load_const(3'd1, 8'd3);
    issue(T_ADD, 3'd1, 3'd1, 3'd5);
    rst = 1'b1;
    model_reset();
    #3;
    rst = 1'b0;
    done_base = done_cnt;
    check("rst_eval_ready", 64'(u_if.cmd_ready), 64'(1));
    check("rst_eval_done", 64'(u_if.done), 64'(0));
    check("rst_eval_flags", 64'(u_if.flags_q), 64'(0));
    check("rst_eval_data_a", 64'(u_if.data_a), 64'(0));
    repeat (3) cycle();
    check("rst_eval_no_done", 64'(done_cnt - done_base), 64'(0));
    rd(3'd5, d);
    check("rst_eval_r5", 64'(d), 64'(0));
    rd(3'd1, d);
    check("rst_eval_r1", 64'(d), 64'(0));

    // 16 x 16 build: status lives in r15
    issue16(T_INC, 4'd0, 4'd0, 4'd2);
    rd16(4'd2, d16);
    check("w16_r2", 64'(d16), 64'(1));
    issue16(T_CAS, 4'd1, 4'd2, 4'd3);
    check("w16_cas1_ok", 64'(cas16), 64'(1));
    rd16(4'd1, d16);
    check("w16_cas1_r1", 64'(d16), 64'(1));
    rd16(4'd15, d16);
    check("w16_cas1_r15", 64'(d16), 64'(1));
    issue16(T_CAS, 4'd1, 4'd2, 4'd3);
    check("w16_cas2_ok", 64'(cas16), 64'(0));
    rd16(4'd3, d16);
    check("w16_cas2_r3", 64'(d16), 64'(1));
    rd16(4'd15, d16);
    check("w16_cas2_r15", 64'(d16), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
